// File: rtl/ultrasonic_echo_emu_if.sv
// Trigger/echo pin bundle between the ranging front-end (master) and the
// emulated sensor (slave).
interface ultrasonic_echo_emu_if;
  logic       trig;
  logic       target_en;
  logic [8:0] distance_cm;
  logic       ech;
  logic       busy;
  logic       trig_err;

  modport master (
    output trig, target_en, distance_cm,
    input  ech, busy, trig_err
  );

  modport slave (
    input  trig, target_en, distance_cm,
    output ech, busy, trig_err
  );
endinterface

// File: rtl/ultrasonic_echo_emu.sv
// Ultrasonic ranging sensor emulator: qualifies the trigger width, waits out
// the burst time, then returns an echo whose width encodes the target range.
module ultrasonic_echo_emu #(
  parameter int unsigned TRIG_MIN_CYC  = 270,
  parameter int unsigned BURST_DLY_CYC = 5400,
  parameter int unsigned CYC_PER_CM    = 1566,
  parameter int unsigned TIMEOUT_CYC   = 1026000,
  parameter int unsigned HOLDOFF_CYC   = 270000
) (
  input logic                  clk,
  input logic                  rst_n,
  ultrasonic_echo_emu_if.slave bus
);

  localparam logic [19:0] TRIG_MIN   = 20'(TRIG_MIN_CYC);
  localparam logic [20:0] BURST_LAST = 21'(BURST_DLY_CYC - 1);
  localparam logic [20:0] HOLD_LAST  = 21'(HOLDOFF_CYC - 1);
  localparam logic [20:0] CPC_W      = 21'(CYC_PER_CM);
  localparam logic [20:0] TIMEOUT_W  = 21'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic        trig_s;
  logic        armed_q, armed_d;
  logic [19:0] tw_q, tw_d;
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] ew_q, ew_d;
  logic        ech_q, ech_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  // Out-of-range or absent targets give the timeout width; very near targets
  // clamp to 2 cm so the echo is never zero cycles wide.
  function automatic logic [20:0] echo_width_f(input logic en, input logic [8:0] d);
    logic [8:0] dc;
    if (!en || d > 9'd400) return TIMEOUT_W;
    dc = (d < 9'd2) ? 9'd2 : d;
    return 21'(dc) * CPC_W;
  endfunction

  assign trig_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      armed_q <= 1'b0;
      tw_q    <= '0;
      cnt_q   <= '0;
      ech_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= bus.trig;
      sync2_q <= sync1_q;
      state_q <= state_d;
      armed_q <= armed_d;
      tw_q    <= tw_d;
      cnt_q   <= cnt_d;
      ech_q   <= ech_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    ew_q <= ew_d;
  end

  always_comb begin
    state_d = state_q;
    armed_d = 1'b0;
    tw_d    = tw_q;
    cnt_d   = cnt_q;
    ew_d    = ew_q;
    err_d   = 1'b0;

    unique case (state_q)
      // armed only after trig_s is seen low here, so a held trigger is ignored
      IDLE: begin
        if (trig_s && armed_q) begin
          state_d = TRIG_HI;
          tw_d    = 20'd1;
        end else begin
          armed_d = armed_q | ~trig_s;
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (tw_q < TRIG_MIN) tw_d = tw_q + 20'd1;
        end else begin
          tw_d = '0;
          if (tw_q >= TRIG_MIN) begin
            state_d = BURST;
            cnt_d   = '0;
            ew_d    = echo_width_f(bus.target_en, bus.distance_cm);
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      BURST: begin
        if (cnt_q == BURST_LAST) begin
          state_d = ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      ECHO: begin
        if (cnt_q == ew_q - 21'd1) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // outputs follow the next state so they change on the same edge as it
    busy_d = (state_d != IDLE) && (state_d != TRIG_HI);
    ech_d  = (state_d == ECHO);
  end

  assign bus.ech      = ech_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = err_q;

endmodule

// File: doc/ultrasonic_echo_emu.md
# ultrasonic_echo_emu

Synthesizable model of the ultrasonic ranging sensor's far end. It watches the trigger line driven by the measurement front-end and answers with an echo pulse whose width encodes a programmable target distance. It sits on the board's trigger/echo pins in place of the physical sensor, for hardware-in-the-loop checks of the trigger generator, echo counter and distance/7-segment path at a repeatable range.

## Interface
Parameters:
- TRIG_MIN_CYC, 270: minimum trigger high time in clk cycles (10 µs at 27 MHz).
- BURST_DLY_CYC, 5400: delay from accepted trigger fall to echo rise (8-cycle 40 kHz burst, 200 µs).
- CYC_PER_CM, 1566: echo cycles per centimetre (58 µs/cm).
- TIMEOUT_CYC, 1026000: echo width for no target or out of range (38 ms).
- HOLDOFF_CYC, 270000: dead time after echo fall before re-arming (10 ms).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- trig  in  1  trigger from the front-end, asynchronous to clk.
- target_en  in  1  1 = target present, 0 = no echo return (timeout width).
- distance_cm  in  9  emulated target range, 0..511 cm.
- ech  out  1  echo pulse to the front-end.
- busy  out  1  high in every state except IDLE and TRIG_HI.
- trig_err  out  1  one-cycle pulse when a trigger shorter than TRIG_MIN_CYC is rejected.

## Operation
- trig passes through a 2-flop synchronizer, giving trig_s. All decisions use trig_s.
- Trigger width counter (20 b) saturates at TRIG_MIN_CYC.
- States:
  - IDLE: wait for trig_s = 1. Go to TRIG_HI and load width = 1.
  - TRIG_HI: increment width while trig_s = 1.
    - On trig_s = 0 with width ≥ TRIG_MIN_CYC: latch target_en and distance_cm, compute echo width, go to BURST.
    - On trig_s = 0 with width < TRIG_MIN_CYC: pulse trig_err and go to IDLE.
  - BURST: count BURST_DLY_CYC cycles, then go to ECHO.
  - ECHO: ech = 1 for exactly echo-width cycles, then go to HOLDOFF.
  - HOLDOFF: count HOLDOFF_CYC cycles, then go to IDLE.
- Echo width is computed from the values latched at trigger fall. Later changes to target_en or distance_cm do not affect the pulse in flight.
  - If the latched target_en = 0 or distance_cm > 400: width = TIMEOUT_CYC.
  - If distance_cm < 2: distance is clamped to 2.
  - Otherwise: width = distance_cm × CYC_PER_CM. The product is computed in 21 bits and does not overflow (400 × 1566 = 626400).
- Trigger activity in BURST, ECHO and HOLDOFF is ignored.
  - A trigger still high on the transition into IDLE is not accepted. A rising edge of trig_s seen in IDLE is required, so trig_s must first be sampled low.
- ech, busy and trig_err are registered outputs.

## Timing
- Reset: on any clk edge with rst_n = 0, the following take effect that edge, including mid-echo:
  - ech = 0, busy = 0, trig_err = 0.
  - State = IDLE; all counters = 0; synchronizer flops = 0.
- Synchronizer latency: 2 cycles from a pin transition to trig_s.
- Edge E is the edge at which TRIG_HI samples trig_s = 0.
  - busy rises at edge E.
  - ech rises at edge E + BURST_DLY_CYC.
  - ech falls at edge E + BURST_DLY_CYC + width.
- ech high time = width cycles exactly; the width is never 0.
- HOLDOFF starts at the ech falling edge. IDLE (busy = 0) is re-entered HOLDOFF_CYC cycles later.
- trig_err is high for exactly one cycle, at edge E, for a rejected trigger.
- Boundary cases:
  - A trigger exactly TRIG_MIN_CYC cycles wide (as seen on trig_s) is accepted.
  - A trigger one cycle shorter is rejected.

## Test plan
Directed tests use reduced parameters TRIG_MIN_CYC=10, BURST_DLY_CYC=20, CYC_PER_CM=3, TIMEOUT_CYC=1500, HOLDOFF_CYC=50.
- 12-cycle trigger, target_en=1, distance_cm=100 → ech rises 20 cycles after E and stays high 300 cycles. busy falls 50 cycles after ech falls. trig_err never asserts.
- 9-cycle trigger → trig_err is a single pulse at E. ech and busy stay 0. A following 10-cycle trigger is accepted.
- distance_cm = 0, then 450, then target_en = 0 → ech widths 6, 1500 and 1500 cycles.
- Second trigger issued during ECHO, and distance_cm changed during BURST → no second echo; the first width equals the latched value × 3.
- rst_n = 0 for one cycle mid-ECHO → ech = 0 at that edge, state IDLE. The next valid trigger produces a correct echo.
- trig held high across HOLDOFF into IDLE → no new echo until trig goes low and rises again.
